// File: rtl/aes_key_pkg.sv
// Shared constants, FSM encoding and byte-level helpers for the AES-128 forward key schedule.
package aes_key_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    AUTO = 2'd2,
    DONE = 2'd3
  } key_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round indices outside 1..10 never reach the datapath; they map to zero to keep the lookup total.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
    logic [7:0] val;
    val = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) val = RCON[int'(r)];
    return val;
  endfunction

endpackage

// File: rtl/aes_fwd_round_fn.sv
// Combinational AES-128 forward key-expansion step: current round key and next round index in, next round key out.
module aes_fwd_round_fn
  import aes_key_pkg::*;
(
  input  logic [KW-1:0] key,
  input  logic [3:0]    r,
  output logic [KW-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign t  = sub_word(rot_word(w3)) ^ {rcon_lookup(r), 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_fwd_key_expand.sv
// AES-128 forward key schedule: loads round key 0, steps to round 10 manually or free-running,
// and captures round key 10 for the inverse-schedule seed.
module aes_fwd_key_expand
  import aes_key_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] cipher_key,
  input  logic          key_load,
  input  logic          auto_run,
  input  logic          rkey_en,
  output logic [KW-1:0] round_key_out,
  output logic [3:0]    round_num,
  output logic          key_valid,
  output logic          busy,
  output logic          done,
  output logic [KW-1:0] round_key_10,
  output logic [1:0]    fsm_state
);

  // key_load and rkey_en are single-cycle pulses with no back-pressure: every asserted cycle is
  // consumed at the next rising edge; key_valid marks round_key_out as usable from the cycle after a load.
  key_state_t    state, state_nxt;
  logic          advance;
  logic          last_step;
  logic [3:0]    round_nxt;
  logic [KW-1:0] next_key;

  assign round_nxt = round_num + 4'd1;
  assign last_step = (round_num == 4'(NR - 1));
  assign fsm_state = state;

  aes_fwd_round_fn u_round_fn (
    .key      (round_key_out),
    .r        (round_nxt),
    .next_key (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = auto_run ? AUTO : STEP;
    end else begin
      case (state)
        STEP:    if (rkey_en && last_step) state_nxt = DONE;
        AUTO:    if (last_step) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Status outputs decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    advance   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    key_valid = 1'b0;
    case (state)
      STEP: begin
        advance   = rkey_en & ~key_load;
        busy      = 1'b1;
        key_valid = 1'b1;
      end
      AUTO: begin
        advance   = ~key_load;
        busy      = 1'b1;
        key_valid = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        key_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_out <= '0;
      round_num     <= 4'd0;
      round_key_10  <= '0;
    end else if (key_load) begin
      round_key_out <= cipher_key;
      round_num     <= 4'd0;
    end else if (advance) begin
      round_key_out <= next_key;
      round_num     <= round_nxt;
      if (last_step) round_key_10 <= next_key;
    end
  end

endmodule

// File: tb/tb_aes_fwd_key_expand.sv
// Directed bench for the AES-128 forward key schedule: table of FIPS-197 / all-zero round keys
// plus hand sequences for gaps, abort-by-reload and mid-run reset.
module tb_aes_fwd_key_expand;

  logic         clk;
  logic         rst_n;
  logic [127:0] cipher_key;
  logic         key_load;
  logic         auto_run;
  logic         rkey_en;
  logic [127:0] round_key_out;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;
  logic [127:0] round_key_10;
  logic [1:0]   fsm_state;

  aes_fwd_key_expand dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cipher_key    (cipher_key),
    .key_load      (key_load),
    .auto_run      (auto_run),
    .rkey_en       (rkey_en),
    .round_key_out (round_key_out),
    .round_num     (round_num),
    .key_valid     (key_valid),
    .busy          (busy),
    .done          (done),
    .round_key_10  (round_key_10),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [127:0] key;
    logic         auto_mode;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic [127:0] fips_exp [10];
  logic [127:0] zero_exp [10];
  vec_t         vecs [20];
  int           gap_pat [16];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at the falling edge after the sampling rise
  task automatic load_key(input logic [127:0] k, input logic a);
    cipher_key = k;
    auto_run   = a;
    key_load   = 1'b1;
    @(negedge clk);
    key_load   = 1'b0;
    auto_run   = 1'b0;
  endtask

  task automatic step(input logic a);
    rkey_en = ~a;
    @(negedge clk);
    rkey_en = 1'b0;
  endtask

  function automatic logic [127:0] fips_round(input int r);
    return (r == 0) ? FIPS_KEY : fips_exp[r-1];
  endfunction

  initial begin
    int exp_rnd;

    rst_n      = 1'b0;
    cipher_key = '0;
    key_load   = 1'b0;
    auto_run   = 1'b0;
    rkey_en    = 1'b0;

    fips_exp = '{
      128'ha0fafe1788542cb123a339392a6c7605, 128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b, 128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc, 128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    zero_exp = '{
      128'h62636363626363636263636362636363, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
      128'h90973450696ccffaf2f457330b0fac99, 128'hee06da7b876a1581759e42b27e91ee2b,
      128'h7f2e2b88f8443e098dda7cbbf34b9290, 128'hec614b851425758c99ff09376ab49ba7,
      128'h217517873550620bacaf6b3cc61bf09b, 128'h0ef903333ba9613897060a04511dfa9f,
      128'hb1d4d8e28a7db9da1d7bb3de4c664941, 128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };
    for (int i = 0; i < 10; i++) begin
      vecs[i]      = '{key: FIPS_KEY, auto_mode: 1'b0, rnd: 4'(i + 1), exp: fips_exp[i]};
      vecs[i + 10] = '{key: ZERO_KEY, auto_mode: 1'b1, rnd: 4'(i + 1), exp: zero_exp[i]};
    end
    gap_pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    // reset state
    #3;
    check("rst_key", round_key_out, 128'h0);
    check("rst_num", 128'(round_num), 128'h0);
    check("rst_valid", 128'(key_valid), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_done", 128'(done), 128'h0);
    check("rst_rk10", round_key_10, 128'h0);
    check("rst_state", 128'(fsm_state), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table: FIPS-197 key in manual mode, then all-zero key free-running
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rnd == 4'd1) begin
        load_key(vecs[i].key, vecs[i].auto_mode);
        check("load_key", round_key_out, vecs[i].key);
        check("load_num", 128'(round_num), 128'h0);
        check("load_valid", 128'(key_valid), 128'h1);
        check("load_busy", 128'(busy), 128'h1);
        check("load_done", 128'(done), 128'h0);
      end
      step(vecs[i].auto_mode);
      check($sformatf("v%0d_key", i), round_key_out, vecs[i].exp);
      check($sformatf("v%0d_num", i), 128'(round_num), 128'(vecs[i].rnd));
      check($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].rnd != 4'd10));
      check($sformatf("v%0d_done", i), 128'(done), 128'(vecs[i].rnd == 4'd10));
      check($sformatf("v%0d_valid", i), 128'(key_valid), 128'h1);
      if (vecs[i].rnd == 4'd10)
        check($sformatf("v%0d_rk10", i), round_key_10, vecs[i].exp);
    end

    // manual mode with gaps, then extra pulses after done
    load_key(FIPS_KEY, 1'b0);
    exp_rnd = 0;
    for (int c = 0; c < 16; c++) begin
      rkey_en = (gap_pat[c] != 0);
      @(negedge clk);
      rkey_en = 1'b0;
      if (gap_pat[c] != 0 && exp_rnd < 10) exp_rnd++;
      check($sformatf("gap%0d_num", c), 128'(round_num), 128'(exp_rnd));
      check($sformatf("gap%0d_key", c), round_key_out, fips_round(exp_rnd));
    end
    check("gap_done", 128'(done), 128'h1);
    check("gap_rk10", round_key_10, fips_exp[9]);
    check("gap_state", 128'(fsm_state), 128'h3);

    // reload with rkey_en at round 5: reload wins, round_key_10 holds until the new round 10
    load_key(FIPS_KEY, 1'b0);
    for (int s = 0; s < 5; s++) step(1'b0);
    check("abort_pre_num", 128'(round_num), 128'h5);
    cipher_key = ZERO_KEY;
    auto_run   = 1'b1;
    key_load   = 1'b1;
    rkey_en    = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    auto_run = 1'b0;
    rkey_en  = 1'b0;
    check("abort_num", 128'(round_num), 128'h0);
    check("abort_key", round_key_out, ZERO_KEY);
    check("abort_done", 128'(done), 128'h0);
    check("abort_busy", 128'(busy), 128'h1);
    check("abort_rk10", round_key_10, fips_exp[9]);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      check($sformatf("abort_r%0d_key", r), round_key_out, zero_exp[r-1]);
      check($sformatf("abort_r%0d_done", r), 128'(done), 128'(r == 10));
      check($sformatf("abort_r%0d_rk10", r), round_key_10, (r == 10) ? zero_exp[9] : fips_exp[9]);
    end

    // asynchronous reset at round 6 of a free-running schedule
    load_key(FIPS_KEY, 1'b1);
    repeat (6) @(negedge clk);
    check("rst6_pre_num", 128'(round_num), 128'h6);
    check("rst6_pre_key", round_key_out, fips_exp[5]);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6_key", round_key_out, 128'h0);
    check("rst6_num", 128'(round_num), 128'h0);
    check("rst6_valid", 128'(key_valid), 128'h0);
    check("rst6_busy", 128'(busy), 128'h0);
    check("rst6_done", 128'(done), 128'h0);
    check("rst6_rk10", round_key_10, 128'h0);
    check("rst6_state", 128'(fsm_state), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", 128'(fsm_state), 128'h0);
    check("post_rst_valid", 128'(key_valid), 128'h0);
    check("post_rst_num", 128'(round_num), 128'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
